// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if
//   Bundles the decode-side operand read ports, the issue request, the
//   writeback bus and the scoreboard status of reg_file_scoreboard.
//
//   Handshake: an issue is offered whenever issue_valid is high and is
//   taken on the rising clock edge only if stall is low in that same
//   cycle (stall acts as the inverted ready). Decode must hold the
//   instruction while stall is high. Writeback has no back-pressure:
//   every cycle with wb_valid high is consumed on the next edge.
//
//   Modports
//     master : decode/writeback side (drives addresses, issue, writeback)
//     slave  : register file (drives read data, stall, pending_count)
interface reg_file_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // operand fetch
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    // issue request
    logic                  issue_valid;
    logic                  issue_uses_a;
    logic                  issue_uses_b;
    logic                  issue_writes;
    logic [ADDR_WIDTH-1:0] issue_dst;
    // writeback
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    // scoreboard status
    logic                  stall;
    logic [ADDR_WIDTH:0]   pending_count;

    modport master (
        output rd_addr_a, rd_addr_b,
        output issue_valid, issue_uses_a, issue_uses_b, issue_writes, issue_dst,
        output wb_valid, wb_addr, wb_data,
        input  rd_data_a, rd_data_b, stall, pending_count
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  issue_valid, issue_uses_a, issue_uses_b, issue_writes, issue_dst,
        input  wb_valid, wb_addr, wb_data,
        output rd_data_a, rd_data_b, stall, pending_count
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Register file with two combinational read ports, one write port fed by
//   writeback, and a per-register pending scoreboard. A register becomes
//   pending when an instruction with that destination issues and stops
//   being pending when its writeback arrives. Decode is stalled
//   combinationally on RAW (rs/rt pending) and WAW (destination pending).
//   Register 0 is hard-wired to zero and is never pending.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous, active-high reset (registers <= RESET_VALUE,
//            scoreboard cleared)
//     bus  : reg_file_scoreboard_if.slave (reads, issue, writeback,
//            stall, pending_count)
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     Defined   : writeback data is forwarded to the read ports in the
//                 writeback cycle, and hazards on the address being written
//                 back are masked, so a dependent issues with no bubble.
//     Undefined : reads see only stored values; a dependent stalls through
//                 the writeback cycle and issues on the following one.
module reg_file_scoreboard #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                  clk,
    input logic                  rst,
    reg_file_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_next;

    logic                  wb_hit_a;
    logic                  wb_hit_b;
    logic                  wb_hit_w;
    logic                  haz_a;
    logic                  haz_b;
    logic                  haz_w;
    logic                  stall;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // wb_hit_* flags a writeback landing on the address in question this
    // cycle; only meaningful with forwarding, otherwise tied low.
    always_comb begin
        wb_hit_a = 1'b0;
        wb_hit_b = 1'b0;
        wb_hit_w = 1'b0;
`ifdef REGFILE_BYPASS_EN
        wb_hit_a = bus.wb_valid && (bus.wb_addr == bus.rd_addr_a);
        wb_hit_b = bus.wb_valid && (bus.wb_addr == bus.rd_addr_b);
        wb_hit_w = bus.wb_valid && (bus.wb_addr == bus.issue_dst);
`endif
    end

    // Hazard detection; address 0 never blocks since it is never pending.
    always_comb begin
        haz_a  = bus.issue_uses_a && pending[bus.rd_addr_a] &&
                 (bus.rd_addr_a != '0) && !wb_hit_a;
        haz_b  = bus.issue_uses_b && pending[bus.rd_addr_b] &&
                 (bus.rd_addr_b != '0) && !wb_hit_b;
        haz_w  = bus.issue_writes && pending[bus.issue_dst] &&
                 (bus.issue_dst != '0) && !wb_hit_w;
        stall  = bus.issue_valid && (haz_a || haz_b || haz_w);
        accept = bus.issue_valid && !stall;
    end

    // Combinational read ports; r0 reads zero whatever is stored there.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (bus.rd_addr_a != '0) begin
            rd_a = wb_hit_a ? bus.wb_data : regs[bus.rd_addr_a];
        end
        if (bus.rd_addr_b != '0) begin
            rd_b = wb_hit_b ? bus.wb_data : regs[bus.rd_addr_b];
        end
    end

    // Next scoreboard: clear on writeback first, then set on accepted issue
    // so a same-cycle set/clear of one register leaves it pending.
    always_comb begin
        pending_next = pending;
        if (bus.wb_valid) begin
            pending_next[bus.wb_addr] = 1'b0;
        end
        if (accept && bus.issue_writes && (bus.issue_dst != '0)) begin
            pending_next[bus.issue_dst] = 1'b1;
        end
        pending_next[0] = 1'b0;

        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + {{ADDR_WIDTH{1'b0}}, pending_next[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
            pending <= '0;
            count_q <= '0;
        end else begin
            if (bus.wb_valid && (bus.wb_addr != '0)) begin
                regs[bus.wb_addr] <= bus.wb_data;
            end
            pending <= pending_next;
            count_q <= count_next;
        end
    end

    assign bus.rd_data_a     = rd_a;
    assign bus.rd_data_b     = rd_b;
    assign bus.stall         = stall;
    assign bus.pending_count = count_q;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard
//   Self-checking bench for reg_file_scoreboard. The driver applies one
//   stimulus vector per cycle, predicts the cycle's outputs from a
//   behavioural model (plain arrays of register values and pending flags)
//   and pushes the prediction into exp_q; a monitor on the falling edge
//   pops and compares against the DUT outputs.
module tb_reg_file_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int EW = 1 + (AW + 1) + 2 * DW;
  localparam logic [DW-1:0] RV = 32'h0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_scoreboard #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  logic [EW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = RV;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a, logic wv,
                                             logic [AW-1:0] wa, logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (BYP && wv && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit ref_haz(logic use_it, logic [AW-1:0] a, logic wv, logic [AW-1:0] wa);
    if (!use_it || a == 0 || !m_pend[a]) return 1'b0;
    if (BYP && wv && wa == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int ref_count();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  task automatic check_now(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic ua, input logic ub, input logic wr,
                       input logic [AW-1:0] dst, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit st;
    logic [AW:0] cnt;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.issue_valid  = iv;
    bus.issue_uses_a = ua;
    bus.issue_uses_b = ub;
    bus.issue_writes = wr;
    bus.issue_dst    = dst;
    bus.rd_addr_a    = ra;
    bus.rd_addr_b    = rb;
    bus.wb_valid     = wv;
    bus.wb_addr      = wa;
    bus.wb_data      = wd;
    st  = iv && (ref_haz(ua, ra, wv, wa) || ref_haz(ub, rb, wv, wa) || ref_haz(wr, dst, wv, wa));
    cnt = (AW + 1)'(ref_count());
    exp_q.push_back({st, cnt, ref_read(ra, wv, wa, wd), ref_read(rb, wv, wa, wd)});
    // state after the coming edge
    if (wv && wa != 0) m_regs[wa] = wd;
    if (wv) m_pend[wa] = 1'b0;
    if (iv && !st && wr && dst != 0) m_pend[dst] = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      rst              = 1'b1;
      bus.issue_valid  = 1'b0;
      bus.issue_uses_a = 1'b0;
      bus.issue_uses_b = 1'b0;
      bus.issue_writes = 1'b0;
      bus.wb_valid     = 1'b0;
      model_reset();
      exp_q.push_back({1'b0, (AW + 1)'(0), ref_read(bus.rd_addr_a, 1'b0, '0, '0),
                       ref_read(bus.rd_addr_b, 1'b0, '0, '0)});
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.stall, bus.pending_count, bus.rd_data_a, bus.rd_data_b};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t: actual stall=%0b cnt=%0d a=%h b=%h required stall=%0b cnt=%0d a=%h b=%h",
                 $time, a[EW-1], a[EW-2 -: AW+1], a[2*DW-1 -: DW], a[DW-1:0],
                 e[EW-1], e[EW-2 -: AW+1], e[2*DW-1 -: DW], e[DW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.issue_valid  = 1'b0;
    bus.issue_uses_a = 1'b0;
    bus.issue_uses_b = 1'b0;
    bus.issue_writes = 1'b0;
    bus.issue_dst    = '0;
    bus.rd_addr_a    = '0;
    bus.rd_addr_b    = '0;
    bus.wb_valid     = 1'b0;
    bus.wb_addr      = '0;
    bus.wb_data      = '0;
    model_reset();
    do_reset(2);

    // r0 writes ignored; r31 visible on both ports
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd31, 32'hCAFEF00D);
    drive(0, 0, 0, 0, 0, 5'd31, 5'd31, 0, 0, 0);
    @(negedge clk);
    check_now("r31_port_a", bus.rd_data_a, 32'hCAFEF00D);
    check_now("r31_port_b", bus.rd_data_b, 32'hCAFEF00D);

    // RAW on r8, resolved by writeback of 0x55
    drive(1, 0, 0, 1, 5'd8, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 5'd8, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 5'd8, 0, 0, 0, 0);
    @(negedge clk);
    check_now("raw_stall", {31'b0, bus.stall}, 32'd1);
    check_now("raw_count", {26'b0, bus.pending_count}, 32'd1);
    drive(1, 1, 0, 0, 0, 5'd8, 0, 1, 5'd8, 32'h55);
    @(negedge clk);
    check_now("wb_cycle_stall", {31'b0, bus.stall}, BYP ? 32'd0 : 32'd1);
    if (BYP) check_now("wb_cycle_bypass", bus.rd_data_a, 32'h55);
    drive(1, 1, 0, 0, 0, 5'd8, 0, 0, 0, 0);
    @(negedge clk);
    check_now("after_wb_stall", {31'b0, bus.stall}, 32'd0);
    check_now("after_wb_data", bus.rd_data_a, 32'h55);

    // same-cycle set and clear of r9: set wins
    drive(1, 0, 0, 1, 5'd9, 0, 0, 1, 5'd9, 32'h99);
    drive(1, 1, 1, 0, 0, 5'd9, 5'd9, 0, 0, 0);
    @(negedge clk);
    check_now("set_wins_stall", {31'b0, bus.stall}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h9A);

    // WAW on r3
    drive(1, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_now("waw_stall", {31'b0, bus.stall}, 32'd1);
    check_now("waw_count", {26'b0, bus.pending_count}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h3);

    // async reset mid-run with pending bits and r5 = 0x1234
    drive(1, 0, 0, 1, 5'd7, 0, 0, 1, 5'd5, 32'h1234);
    drive(0, 0, 0, 0, 0, 5'd5, 5'd5, 0, 0, 0);
    do_reset(1);
    drive(0, 0, 0, 0, 0, 5'd5, 5'd5, 0, 0, 0);
    @(negedge clk);
    check_now("reset_r5", bus.rd_data_a, RV);
    check_now("reset_count", {26'b0, bus.pending_count}, 32'd0);

    // fill the scoreboard, then drain it
    for (int d = 1; d < NR; d++) drive(1, 0, 0, 1, AW'(d), 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    check_now("full_count", {26'b0, bus.pending_count}, 32'd31);
    for (int d = 1; d < NR; d++) drive(0, 0, 0, 0, 0, 0, 0, 1, AW'(d), $urandom);
    drive(1, 1, 1, 1, 5'd4, 5'd6, 5'd12, 0, 0, 0);
    @(negedge clk);
    check_now("drained_count", {26'b0, bus.pending_count}, 32'd0);
    check_now("drained_stall", {31'b0, bus.stall}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
              AW'($urandom), AW'($urandom), AW'($urandom),
              $urandom_range(0, 1) == 1, AW'($urandom), $urandom);
      end
    end
    idle();

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: actual %0d entries left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
